// File: rtl/dma_int_queue_reader.sv
// Purpose: consumer end of the DMA interrupt event queue; pops one event, presents it masked to software, waits for W1C.
// Latency: rdEn is registered one cycle after fifoEmpty is seen low; intStatus is valid RD_LATENCY+1 cycles after the rdEn cycle; intr follows one cycle later.
// Backpressure: no new pop is issued until software has cleared every presented bit; fully masked events are dropped and counted.
//
// Ports:
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   fifoEmpty, rdData, rdEn queue read port (rdEn is a single-cycle pop strobe)
//   intMask                 per-cause enable, applied only when the event is captured
//   clrEn, clrData          write-1-to-clear strobe and pattern from the register block
//   intStatus, intr         presented (masked) event and the CPU interrupt request
//   busy                    high whenever the reader is not idle
//   servicedCnt, discardCnt saturating event counters
module dma_int_queue_reader #(
  parameter int FIFO_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  fifoEmpty,
  input  logic [FIFO_WIDTH-1:0] rdData,
  output logic                  rdEn,
  input  logic [FIFO_WIDTH-1:0] intMask,
  input  logic                  clrEn,
  input  logic [FIFO_WIDTH-1:0] clrData,
  output logic [FIFO_WIDTH-1:0] intStatus,
  output logic                  intr,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  servicedCnt,
  output logic [CNT_WIDTH-1:0]  discardCnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  // RD_LATENCY is at most 3, so the countdown fits in two bits.
  localparam int                LAT_W    = 2;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state;
  logic [LAT_W-1:0]        latCnt;
  logic [FIFO_WIDTH-1:0]   cap;
  logic [FIFO_WIDTH-1:0]   clrResult;

  // The mask is applied once, at capture; later mask changes leave intStatus alone.
  assign cap       = rdData & intMask;
  // Clear bits that are not currently set simply have no effect.
  assign clrResult = intStatus & ~clrData;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      latCnt      <= '0;
      rdEn        <= 1'b0;
      intStatus   <= '0;
      intr        <= 1'b0;
      busy        <= 1'b0;
      servicedCnt <= '0;
      discardCnt  <= '0;
    end else begin
      rdEn <= 1'b0;
      case (state)
        IDLE: begin
          // fifoEmpty is trustworthy here because the previous pop finished
          // at least RD_LATENCY+2 cycles ago.
          if (!fifoEmpty) begin
            state <= POP;
            rdEn  <= 1'b1;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        POP: begin
          latCnt <= LAT_LOAD;
          state  <= WAIT;
        end

        WAIT: begin
          // latCnt reaches zero in the cycle rdData is valid.
          if (latCnt == '0) begin
            if (cap != '0) begin
              intStatus <= cap;
              state     <= PRESENT;
            end else begin
              if (discardCnt != CNT_MAX) begin
                discardCnt <= discardCnt + 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            latCnt <= latCnt - 1'b1;
          end
        end

        PRESENT: begin
          if (clrEn) begin
            intStatus <= clrResult;
            if (clrResult == '0) begin
              if (servicedCnt != CNT_MAX) begin
                servicedCnt <= servicedCnt + 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
              intr  <= 1'b0;
            end else begin
              intr  <= 1'b1;
            end
          end else begin
            intr <= |intStatus;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_int_queue_reader.sv
module tb_dma_int_queue_reader;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic [W-1:0]  rdData = '0;
  logic          rdEn;
  logic [W-1:0]  intMask = '0;
  logic          clrEn = 1'b0;
  logic [W-1:0]  clrData = '0;
  logic [W-1:0]  intStatus;
  logic          intr;
  logic          busy;
  logic [CW-1:0] servicedCnt;
  logic [CW-1:0] discardCnt;

  dma_int_queue_reader #(.FIFO_WIDTH(W), .RD_LATENCY(L), .CNT_WIDTH(CW)) dut (
    .clock(clock), .resetn(resetn), .fifoEmpty(fifoEmpty), .rdData(rdData), .rdEn(rdEn),
    .intMask(intMask), .clrEn(clrEn), .clrData(clrData), .intStatus(intStatus), .intr(intr),
    .busy(busy), .servicedCnt(servicedCnt), .discardCnt(discardCnt)
  );

  always #5 clock = ~clock;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;
  always @(posedge clock) cyc++;

  // Behavioural queue: a popped word appears on rdData exactly L cycles after
  // the rdEn cycle and is garbage at every other time.
  logic [W-1:0] fq[$];
  logic [W-1:0] popVal = '0;
  int popCnt  = 0;
  int lastPop = 0;
  int nPops   = 0;
  int totPops = 0;

  always @(negedge clock) begin
    if (!resetn) begin
      popCnt = 0;
      nPops  = 0;
      rdData = W'($urandom);
    end else begin
      if (popCnt > 0) begin
        popCnt--;
        rdData = (popCnt == 0) ? popVal : W'($urandom);
      end else begin
        rdData = W'($urandom);
      end
      if (rdEn) begin
        nCmp++;
        assert (fifoEmpty === 1'b0) else begin
          nErr++;
          $error("FAIL rdEn_while_empty: observed fifoEmpty=%0b expected 0", fifoEmpty);
        end
        if (nPops > 0) begin
          nCmp++;
          assert (cyc - lastPop >= L + 2) else begin
            nErr++;
            $error("FAIL pop_spacing: observed %0d cycles expected >= %0d", cyc - lastPop, L + 2);
          end
        end
        lastPop = cyc;
        nPops++;
        totPops++;
        if (fq.size() > 0) begin
          popVal = fq.pop_front();
          popCnt = L;
        end
      end
    end
    fifoEmpty = (fq.size() == 0);
  end

  int expServ = 0;
  int expDisc = 0;

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    fifoEmpty = 1'b0;
  endtask

  task automatic waitRdEn();
    int t;
    t = 0;
    while (rdEn !== 1'b1 && t < 60) begin
      @(negedge clock);
      t++;
    end
    chk("pop_timeout", 32'(t < 60), 32'd1);
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (!(fifoEmpty && busy === 1'b0 && popCnt == 0) && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", 32'(t < 100), 32'd1);
  endtask

  // Software agent: wait for the event, compare it, then write-1-clear it
  // (randomly in pieces when partial is set) tracking the expected residue.
  task automatic service(input logic [W-1:0] expv, input bit partial);
    int t;
    int i;
    logic [W-1:0] m;
    logic [W-1:0] c;
    t = 0;
    while (intStatus === '0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    chk("present_timeout", 32'(t < 60), 32'd1);
    if (t < 60) begin
      chk("intStatus_capture", 32'(intStatus), 32'(expv));
      m = expv;
      i = 0;
      while (m != '0) begin
        if (partial && i < 6) c = (m & W'($urandom)) | (~expv & W'($urandom));
        else                  c = m | (W'($urandom) & ~m);
        clrEn   = 1'b1;
        clrData = c;
        @(negedge clock);
        clrEn   = 1'b0;
        clrData = W'($urandom);
        m = m & ~c;
        i++;
        chk("intStatus_after_clr", 32'(intStatus), 32'(m));
        chk("intr_after_clr", 32'(intr), 32'(m != '0));
        if (m == '0) expServ++;
      end
      chk("servicedCnt", 32'(servicedCnt), 32'(sat(expServ)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] vals[4];
    int p0;

    // Reset state
    #1;
    chk("rst_rdEn", 32'(rdEn), 32'd0);
    chk("rst_intStatus", 32'(intStatus), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_servicedCnt", 32'(servicedCnt), 32'd0);
    chk("rst_discardCnt", 32'(discardCnt), 32'd0);
    intMask = 8'hFF;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Single event: pop strobe, capture latency, registered intr
    push(8'h05);
    waitRdEn();
    chk("pop_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("pop_single_cycle", 32'(rdEn), 32'd0);
    repeat (L - 1) @(negedge clock);
    chk("before_capture", 32'(intStatus), 32'd0);
    @(negedge clock);
    chk("capture_value", 32'(intStatus), 32'h05);
    chk("intr_not_yet", 32'(intr), 32'd0);
    @(negedge clock);
    chk("intr_rises", 32'(intr), 32'd1);

    // Partial then final clear, with the next event already queued
    push(8'h81);
    clrEn = 1'b1; clrData = 8'h01;
    @(negedge clock);
    clrEn = 1'b0;
    chk("partial_clr_status", 32'(intStatus), 32'h04);
    chk("partial_clr_intr", 32'(intr), 32'd1);
    clrEn = 1'b1; clrData = 8'h04;
    @(negedge clock);
    clrEn = 1'b0;
    expServ++;
    chk("final_clr_status", 32'(intStatus), 32'd0);
    chk("final_clr_intr", 32'(intr), 32'd0);
    chk("final_clr_serviced", 32'(servicedCnt), 32'(expServ));
    service(8'h81, 1'b1);
    waitIdle();

    // Fully masked event is discarded
    intMask = 8'h0F;
    push(8'h30);
    expDisc++;
    waitIdle();
    chk("discardCnt", 32'(discardCnt), 32'(expDisc));
    chk("discard_intr", 32'(intr), 32'd0);
    chk("discard_status", 32'(intStatus), 32'd0);
    chk("discard_busy", 32'(busy), 32'd0);

    // clrEn while idle and during the capture cycle is ignored
    intMask = 8'hFF;
    clrEn = 1'b1; clrData = 8'hFF;
    @(negedge clock);
    clrEn = 1'b0;
    push(8'h3C);
    waitRdEn();
    repeat (L) @(negedge clock);
    clrEn = 1'b1; clrData = 8'hFF;
    @(negedge clock);
    clrEn = 1'b0;
    chk("clr_in_capture_ignored", 32'(intStatus), 32'h3C);
    service(8'h3C, 1'b0);
    waitIdle();

    // Mask change while presenting leaves the latched value intact
    intMask = 8'h7E;
    push(8'hFF);
    waitRdEn();
    repeat (L + 1) @(negedge clock);
    intMask = 8'h00;
    service(8'h7E, 1'b1);
    intMask = 8'hFF;
    waitIdle();

    // Four back-to-back events, cleared as soon as they appear
    p0 = totPops;
    for (int k = 0; k < 4; k++) begin
      vals[k] = W'($urandom_range(1, 255));
      push(vals[k]);
    end
    for (int k = 0; k < 4; k++) service(vals[k], 1'b0);
    waitIdle();
    chk("burst_pop_count", 32'(totPops - p0), 32'd4);

    // Reset during WAIT
    push(8'h55);
    waitRdEn();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    fq.delete();
    fifoEmpty = 1'b1;
    #1;
    chk("arst_rdEn", 32'(rdEn), 32'd0);
    chk("arst_intr", 32'(intr), 32'd0);
    chk("arst_intStatus", 32'(intStatus), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_servicedCnt", 32'(servicedCnt), 32'd0);
    expServ = 0;
    expDisc = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    v = W'($urandom_range(1, 255));
    push(v);
    service(v, 1'b1);
    waitIdle();

    // Saturation of servicedCnt
    for (int k = 0; k < 260; k++) begin
      v = W'($urandom_range(1, 255));
      push(v);
      service(v, k[0]);
    end
    waitIdle();
    chk("serviced_saturated", 32'(servicedCnt), 32'd255);
    chk("discard_after_rst", 32'(discardCnt), 32'(expDisc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
